// File: rtl/ram_bank_arb.sv
// ram_bank_arb: two-requester round-robin arbiter and read sequencer for a dual-port ram_bank
module ram_bank_arb #(
   parameter int ADDR_BIT = 3,
   parameter int DATA_BIT = 16,
   parameter int RD_LAT   = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                r0_req,
   input  logic                r0_we,
   input  logic [ADDR_BIT-1:0] r0_addr,
   input  logic [DATA_BIT-1:0] r0_wdata,
   output logic                r0_gnt,
   output logic                r0_rvalid,
   output logic [DATA_BIT-1:0] r0_rdata,
   input  logic                r1_req,
   input  logic                r1_we,
   input  logic [ADDR_BIT-1:0] r1_addr,
   input  logic [DATA_BIT-1:0] r1_wdata,
   output logic                r1_gnt,
   output logic                r1_rvalid,
   output logic [DATA_BIT-1:0] r1_rdata,
   output logic                en,
   output logic                we,
   output logic                re,
   output logic [ADDR_BIT-1:0] addr_w,
   output logic [DATA_BIT-1:0] d_w,
   output logic [ADDR_BIT-1:0] addr_r,
   input  logic [DATA_BIT-1:0] d_r
);
   localparam int T = RD_LAT - 1;
   logic                wptr, rptr;
   logic                wc0, wc1, rc0, rc1, w_win, r_win;
   logic [RD_LAT-1:0]   p_valid, p_id, p_byp;
   logic [DATA_BIT-1:0] p_bdata [RD_LAT];
   logic [DATA_BIT-1:0] tail_data;
   // candidates are masked by reset so grants and strobes stay low while rst_n is low
   assign wc0 = rst_n & r0_req & r0_we;
   assign wc1 = rst_n & r1_req & r1_we;
   assign rc0 = rst_n & r0_req & ~r0_we;
   assign rc1 = rst_n & r1_req & ~r1_we;
   assign w_win = (wc0 & wc1) ? wptr : wc1;
   assign r_win = (rc0 & rc1) ? rptr : rc1;
   assign we = wc0 | wc1;
   assign re = rc0 | rc1;
   assign en = we | re;
   assign r0_gnt = (wc0 & ~w_win) | (rc0 & ~r_win);
   assign r1_gnt = (wc1 & w_win) | (rc1 & r_win);
   assign addr_w = !we ? '0 : w_win ? r1_addr : r0_addr;
   assign d_w    = !we ? '0 : w_win ? r1_wdata : r0_wdata;
   assign addr_r = !re ? '0 : r_win ? r1_addr : r0_addr;
   assign tail_data = p_byp[T] ? p_bdata[T] : d_r;
   assign r0_rvalid = p_valid[T] & ~p_id[T];
   assign r1_rvalid = p_valid[T] & p_id[T];
   assign r0_rdata  = r0_rvalid ? tail_data : '0;
   assign r1_rdata  = r1_rvalid ? tail_data : '0;
   // round-robin pointers favour the loser of each accepted operation on their own port
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr <= 1'b0;
         rptr <= 1'b0;
      end else begin
         if (we) wptr <= ~w_win;
         if (re) rptr <= ~r_win;
      end
   end
   // in-flight read tracker; a same-address write in the read cycle is captured for bypass
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_valid <= '0;
         p_id    <= '0;
         p_byp   <= '0;
         for (int i = 0; i < RD_LAT; i++) p_bdata[i] <= '0;
      end else begin
         p_valid[0] <= re;
         p_id[0]    <= r_win;
         p_byp[0]   <= we & re & (addr_w == addr_r);
         p_bdata[0] <= d_w;
         for (int i = 1; i < RD_LAT; i++) begin
            p_valid[i] <= p_valid[i-1];
            p_id[i]    <= p_id[i-1];
            p_byp[i]   <= p_byp[i-1];
            p_bdata[i] <= p_bdata[i-1];
         end
      end
   end
endmodule

// File: tb/tb_ram_bank_arb.sv
// tb_ram_bank_arb: directed stimulus with a queue scoreboard for read responses
module tb_ram_bank_arb;
   localparam int RD_LAT = 1;
   logic        clk = 0, rst_n = 0;
   logic        r0_req = 0, r0_we = 0, r1_req = 0, r1_we = 0;
   logic [2:0]  r0_addr = 0, r1_addr = 0, addr_w, addr_r;
   logic [15:0] r0_wdata = 0, r1_wdata = 0, r0_rdata, r1_rdata, d_w, d_r;
   logic        r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, en, we, re;
   logic [15:0] mem [8];
   int          cyc = 0, tests = 0, fails = 0;
   typedef struct {int cyc; logic id; logic [15:0] data;} exp_t;
   exp_t q[$];
   exp_t e;

   ram_bank_arb #(.ADDR_BIT(3), .DATA_BIT(16), .RD_LAT(RD_LAT)) dut (
      .clk(clk), .rst_n(rst_n),
      .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
      .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
      .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
      .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
      .en(en), .we(we), .re(re), .addr_w(addr_w), .d_w(d_w), .addr_r(addr_r), .d_r(d_r));

   always #5 clk = ~clk;

   // bank model: read-before-write, one-cycle synchronous read, contents survive reset
   initial begin
      for (int i = 0; i < 8; i++) mem[i] = 16'h0;
      d_r = 16'h0;
   end
   always @(posedge clk) begin
      cyc++;
      if (we) mem[addr_w] <= d_w;
      if (re) d_r <= mem[addr_r];
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic set0(input logic q_, input logic w, input logic [2:0] a, input logic [15:0] d);
      r0_req = q_; r0_we = w; r0_addr = a; r0_wdata = d;
   endtask

   task automatic set1(input logic q_, input logic w, input logic [2:0] a, input logic [15:0] d);
      r1_req = q_; r1_we = w; r1_addr = a; r1_wdata = d;
   endtask

   task automatic tick(input logic eg0, input logic eg1, input logic [15:0] ed0, input logic [15:0] ed1);
      @(negedge clk);
      chk("r0_gnt", r0_gnt, eg0);
      chk("r1_gnt", r1_gnt, eg1);
      if (eg0 && r0_req && !r0_we) q.push_back('{cyc + RD_LAT, 1'b0, ed0});
      if (eg1 && r1_req && !r1_we) q.push_back('{cyc + RD_LAT, 1'b1, ed1});
      @(posedge clk); #1;
   endtask

   // monitor: every response must match the head of the scoreboard in cycle, id and data
   always @(negedge clk) if (rst_n) begin
      if (q.size() > 0 && q[0].cyc < cyc) begin
         tests++; fails++;
         $display("FAIL rsp_missing: no rvalid in cycle %0d for id %0d, wanted data %0h", q[0].cyc, q[0].id, q[0].data);
         void'(q.pop_front());
      end
      if (r0_rvalid || r1_rvalid) begin
         chk("rvalid_excl", {31'b0, r0_rvalid & r1_rvalid}, 0);
         if (q.size() == 0) begin
            tests++; fails++;
            $display("FAIL rsp_unexpected: rvalid r0=%0b r1=%0b with nothing pending (cycle %0d)", r0_rvalid, r1_rvalid, cyc);
         end else begin
            e = q.pop_front();
            chk("rsp_cycle", cyc, e.cyc);
            chk("rsp_id", {31'b0, r1_rvalid}, {31'b0, e.id});
            chk("rsp_data", e.id ? r1_rdata : r0_rdata, e.data);
         end
      end
   end

   initial begin
      set0(1, 1, 2, 16'h0002);
      repeat (3) begin
         @(negedge clk);
         chk("rst_gnt", {r1_gnt, r0_gnt}, 0);
         chk("rst_strobes", {en, we, re}, 0);
         chk("rst_rvalid", {r1_rvalid, r0_rvalid}, 0);
      end
      @(posedge clk); #1 rst_n = 1;
      @(negedge clk);
      chk("first_gnt", r0_gnt, 1);
      chk("first_we", {en, we, re}, 3'b110);
      chk("first_addr_w", addr_w, 2);
      chk("first_d_w", d_w, 16'h0002);
      @(posedge clk); #1;
      for (int a = 0; a < 8; a++) begin
         set0(1, 1, 3'(a), 16'(a));
         tick(1, 0, 0, 0);
      end
      for (int a = 0; a < 8; a++) begin
         set0(1, 0, 3'(a), 0);
         tick(1, 0, 16'(a), 0);
      end
      set0(0, 0, 0, 0);
      set1(1, 1, 2, 16'h0002);
      tick(0, 1, 0, 0);
      set0(1, 1, 1, 16'hAAAA);
      set1(1, 1, 1, 16'h5555);
      tick(1, 0, 0, 0);
      tick(0, 1, 0, 0);
      tick(1, 0, 0, 0);
      tick(0, 1, 0, 0);
      set1(0, 0, 0, 0);
      set0(1, 0, 1, 0);
      tick(1, 0, 16'h5555, 0);
      set0(1, 1, 3, 16'h000A);
      set1(1, 0, 3, 0);
      tick(1, 1, 0, 16'h000A);
      set0(1, 1, 3, 16'h000B);
      set1(1, 0, 4, 0);
      tick(1, 1, 0, 16'h0004);
      set0(1, 0, 5, 0);
      set1(1, 0, 6, 0);
      tick(1, 0, 16'h0005, 0);
      tick(0, 1, 0, 16'h0006);
      tick(1, 0, 16'h0005, 0);
      tick(0, 1, 0, 16'h0006);
      set0(0, 0, 0, 0);
      set1(1, 0, 7, 0);
      @(negedge clk);
      chk("mid_rst_gnt", r1_gnt, 1);
      @(posedge clk); #1 rst_n = 0;
      set1(0, 0, 0, 0);
      repeat (2) begin
         @(negedge clk);
         chk("mid_rst_rvalid", {r1_rvalid, r0_rvalid}, 0);
      end
      @(posedge clk); #1 rst_n = 1;
      set0(1, 0, 7, 0);
      tick(1, 0, 16'h0007, 0);
      set0(0, 0, 0, 0);
      repeat (3) @(negedge clk);
      chk("scoreboard_drained", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
